// File: rtl/drum_voice_mixer_pkg.sv
// Shared constants for the drum voice mixer: voice count, default voice timing
// and the noise LFSR definition (used only when DRUM_NOISE_EN is defined).
package drum_pkg;

   localparam int unsigned NUM_VOICES     = 5;
   localparam int unsigned DEF_ENV_W      = 8;
   localparam int unsigned DEF_DECAY_DIV  = 2048;
   localparam int unsigned DEF_HALF_PER_A = 4000;
   localparam int unsigned DEF_HALF_PER_B = 2500;
   localparam int unsigned DEF_HALF_PER_C = 1500;
   localparam int unsigned DEF_HALF_PER_D = 900;
   localparam int unsigned DEF_HALF_PER_E = 500;

   // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/drum_voice_mixer_if.sv
// Step/trigger inputs from the sequencer and the audio outputs of the mixer.
interface drum_voice_mixer_if
   import drum_pkg::*;
#(
   parameter int unsigned PWM_W = DEF_ENV_W + 3
) ();

   logic                  Step_tick;
   logic                  Playing;
   logic [NUM_VOICES-1:0] Trig;
   logic [NUM_VOICES-1:0] Voice_active;
   logic [PWM_W-1:0]      Mix;
   logic                  Audio_pwm;

   modport master (
      output Step_tick, Playing, Trig,
      input  Voice_active, Mix, Audio_pwm
   );

   modport slave (
      input  Step_tick, Playing, Trig,
      output Voice_active, Mix, Audio_pwm
   );

endinterface

// File: rtl/drum_voice.sv
// One drum voice: linear-decay envelope gating a square tone (or LFSR noise
// when NOISE=1). Sample is the envelope while the tone bit is high, else 0.
module drum_voice
   import drum_pkg::*;
#(
   parameter int unsigned ENV_W     = DEF_ENV_W,
   parameter int unsigned DECAY_DIV = DEF_DECAY_DIV,
   parameter int unsigned HALF_PER  = DEF_HALF_PER_A,
   parameter int unsigned NOISE     = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             fire,
   input  logic             mute,
   output logic [ENV_W-1:0] sample,
   output logic             active
);

   localparam int unsigned DC_W = $clog2(DECAY_DIV);
   localparam int unsigned PH_W = $clog2(HALF_PER);
   localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DECAY_DIV - 1);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(HALF_PER - 1);
   localparam logic [ENV_W-1:0] ENV_MAX = '1;

   logic [ENV_W-1:0] env_d, env_q;
   logic [DC_W-1:0]  dcnt_d, dcnt_q;
   logic [PH_W-1:0]  phase_d, phase_q;
   logic             sq_d, sq_q;
   logic             fire_go;
   logic             ph_wrap;
   logic             tone_bit;

   // Mute outranks a trigger; a trigger outranks a natural phase wrap
   assign fire_go = fire & ~mute;
   assign ph_wrap = (phase_q == PH_LAST) & ~fire_go;

   // Envelope: restart on fire, otherwise step down once per DECAY_DIV cycles
   always_comb begin
      env_d  = env_q;
      dcnt_d = dcnt_q;
      if (mute) begin
         env_d  = '0;
         dcnt_d = '0;
      end else if (fire_go) begin
         env_d  = ENV_MAX;
         dcnt_d = '0;
      end else if (env_q != '0) begin
         if (dcnt_q == DC_LAST) begin
            dcnt_d = '0;
            env_d  = env_q - ENV_W'(1);
         end else begin
            dcnt_d = dcnt_q + DC_W'(1);
         end
      end else begin
         dcnt_d = '0;
      end
   end

   // Tone runs continuously, independent of the envelope
   always_comb begin
      phase_d = phase_q + PH_W'(1);
      sq_d    = sq_q;
      if (fire_go) begin
         phase_d = '0;
         sq_d    = 1'b1;
      end else if (ph_wrap) begin
         phase_d = '0;
         sq_d    = ~sq_q;
      end
   end

   // Voice state registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         env_q   <= '0;
         dcnt_q  <= '0;
         phase_q <= '0;
         sq_q    <= 1'b0;
      end else begin
         env_q   <= env_d;
         dcnt_q  <= dcnt_d;
         phase_q <= phase_d;
         sq_q    <= sq_d;
      end
   end

   if (NOISE != 0) begin : g_noise
      logic [15:0] lfsr_d, lfsr_q;

      // Noise advances on each natural phase wrap; a fire does not reseed it
      always_comb begin
         lfsr_d = ph_wrap ? lfsr_next(lfsr_q) : lfsr_q;
      end

      // LFSR register
      always_ff @(posedge Clk or posedge Reset) begin
         if (Reset) lfsr_q <= LFSR_SEED;
         else       lfsr_q <= lfsr_d;
      end

      assign tone_bit = lfsr_q[0];
   end else begin : g_square
      assign tone_bit = sq_q;
   end

   assign sample = tone_bit ? env_q : '0;
   assign active = (env_q != '0);

endmodule

// File: rtl/drum_voice_mixer.sv
// Five-voice drum mixer: decodes step triggers into voice fires, sums the
// voice samples into a registered mix word and drives a PWM DAC bit.
// Build option: define DRUM_NOISE_EN to turn voice E into LFSR noise.
module drum_voice_mixer
   import drum_pkg::*;
#(
   parameter int unsigned ENV_W      = DEF_ENV_W,
   parameter int unsigned DECAY_DIV  = DEF_DECAY_DIV,
   parameter int unsigned HALF_PER_A = DEF_HALF_PER_A,
   parameter int unsigned HALF_PER_B = DEF_HALF_PER_B,
   parameter int unsigned HALF_PER_C = DEF_HALF_PER_C,
   parameter int unsigned HALF_PER_D = DEF_HALF_PER_D,
   parameter int unsigned HALF_PER_E = DEF_HALF_PER_E,
   parameter int unsigned PWM_W      = ENV_W + 3
) (
   input logic               Clk,
   input logic               Reset,
   drum_voice_mixer_if.slave bus
);

`ifdef DRUM_NOISE_EN
   localparam int unsigned NOISE_E = 1;
`else
   localparam int unsigned NOISE_E = 0;
`endif

   logic [NUM_VOICES-1:0] fire;
   logic [NUM_VOICES-1:0] active;
   logic                  mute;
   logic [ENV_W-1:0]      sample [NUM_VOICES];

   logic [PWM_W-1:0] mix_d, mix_q;
   logic [PWM_W-1:0] cnt_d, cnt_q;
   logic [PWM_W-1:0] duty_d, duty_q;
   logic             pwm_d, pwm_q;

   assign mute = ~bus.Playing;
   assign fire = (bus.Step_tick && bus.Playing) ? bus.Trig : '0;

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
      localparam int unsigned HP = (i == 0) ? HALF_PER_A :
                                   (i == 1) ? HALF_PER_B :
                                   (i == 2) ? HALF_PER_C :
                                   (i == 3) ? HALF_PER_D : HALF_PER_E;
      localparam int unsigned NZ = (i == NUM_VOICES - 1) ? NOISE_E : 0;

      drum_voice #(
         .ENV_W     (ENV_W),
         .DECAY_DIV (DECAY_DIV),
         .HALF_PER  (HP),
         .NOISE     (NZ)
      ) u_voice (
         .Clk    (Clk),
         .Reset  (Reset),
         .fire   (fire[i]),
         .mute   (mute),
         .sample (sample[i]),
         .active (active[i])
      );
   end

   // Sum of voice samples; 5 * (2^ENV_W - 1) always fits in PWM_W bits
   always_comb begin
      mix_d = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         mix_d = mix_d + PWM_W'(sample[i]);
      end
   end

   // PWM: duty only reloads at counter wrap so a period is never split
   always_comb begin
      cnt_d  = cnt_q + PWM_W'(1);
      duty_d = (cnt_q == '1) ? mix_q : duty_q;
      pwm_d  = (cnt_q < duty_q);
   end

   // Mix and PWM registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mix_q  <= '0;
         cnt_q  <= '0;
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         mix_q  <= mix_d;
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign bus.Voice_active = active;
   assign bus.Mix          = mix_q;
   assign bus.Audio_pwm    = pwm_q;

endmodule
